// File: rtl/branch_flush_ctrl_if.sv
// Branch/flush control bundle between ID/EX registers and PC/IF-ID control.
// The master drives the ID/EX side inputs; the slave is the flush controller.
interface branch_flush_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_opCode;
    logic             ex_setsFlags;
    logic             flag_we;
    logic             C_new;
    logic             Z_new;
    logic             stall;
    logic             pc_src;
    logic             flush;
    logic             C_out;
    logic             Z_out;
    logic [CNT_W-1:0] br_taken_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_opCode, ex_setsFlags,
        output flag_we, C_new, Z_new,
        input  stall, pc_src, flush, C_out, Z_out,
        input  br_taken_cnt, stall_cnt
    );

    modport slave (
        input  id_valid, id_opCode, ex_setsFlags,
        input  flag_we, C_new, Z_new,
        output stall, pc_src, flush, C_out, Z_out,
        output br_taken_cnt, stall_cnt
    );
endinterface

// File: rtl/branch_flush_ctrl.sv
// Resolves conditional branches in ID against the C/Z flags, stalling one
// cycle on a flag hazard and flushing IF/ID for FLUSH_CYCLES on a taken branch.
module branch_flush_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    branch_flush_ctrl_if.slave  ctrl
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t           state;
    logic [3:0]       flushCnt;
    logic             cFlag;
    logic             zFlag;
    logic [CNT_W-1:0] brCnt;
    logic [CNT_W-1:0] stallCnt;

    logic isBr;
    logic cond;
    logic taken;
    logic stallD;
    logic pcSrcD;
    logic flushD;

    always_comb begin
        isBr = ctrl.id_valid && (ctrl.id_opCode[4:2] == 3'b101);
        cond = 1'b0;
        unique case (ctrl.id_opCode[1:0])
            2'b00:   cond = zFlag;
            2'b01:   cond = !zFlag;
            2'b10:   cond = cFlag;
            default: cond = !cFlag;
        endcase
        taken = isBr && cond;
    end

    // Outputs are Mealy and forced low while reset is held.
    always_comb begin
        stallD = 1'b0;
        pcSrcD = 1'b0;
        flushD = 1'b0;
        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (isBr && ctrl.ex_setsFlags) begin
                        stallD = 1'b1;
                    end else if (taken) begin
                        pcSrcD = 1'b1;
                        flushD = 1'b1;
                    end
                end
                STALL: begin
                    if (taken) begin
                        pcSrcD = 1'b1;
                        flushD = 1'b1;
                    end
                end
                FLUSH: flushD = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            flushCnt <= 4'd0;
            cFlag    <= 1'b0;
            zFlag    <= 1'b0;
            brCnt    <= '0;
            stallCnt <= '0;
        end else begin
            if (ctrl.flag_we) begin
                cFlag <= ctrl.C_new;
                zFlag <= ctrl.Z_new;
            end
            if (stallD && (stallCnt != '1)) stallCnt <= stallCnt + 1'b1;
            if (pcSrcD && (brCnt != '1)) brCnt <= brCnt + 1'b1;
            unique case (state)
                RUN, STALL: begin
                    if (stallD) begin
                        state <= STALL;
                    end else if (pcSrcD) begin
                        state    <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                        flushCnt <= 4'(FLUSH_CYCLES - 1);
                    end else begin
                        state <= RUN;
                    end
                end
                FLUSH: begin
                    if (flushCnt <= 4'd1) state <= RUN;
                    else flushCnt <= flushCnt - 4'd1;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign ctrl.stall        = stallD;
    assign ctrl.pc_src       = pcSrcD;
    assign ctrl.flush        = flushD;
    assign ctrl.C_out        = cFlag;
    assign ctrl.Z_out        = zFlag;
    assign ctrl.br_taken_cnt = brCnt;
    assign ctrl.stall_cnt    = stallCnt;
endmodule
